// File: rtl/ntt_pkg.sv
// Shared NTT constants and the mo_mul issue tag.
// Provides DATA_WIDTH, Q, Q_M, Q_K, MUL_LAT and mul_tag_s.
package ntt_pkg;

    localparam int DATA_WIDTH = 14;
    localparam int Q          = 12289;
    // -Q^-1 mod 2^DATA_WIDTH (Montgomery constant)
    localparam int Q_M        = 12287;
    // Q = Q_K * 2^12 + 1 (K-RED constant)
    localparam int Q_K        = 3;
    // MWR2MM: one cycle per operand bit plus in/out stages
    localparam int MUL_LAT    = DATA_WIDTH + 2;

    localparam int N_REQ_MAX  = 8;
    localparam int TAG_ID_W   = $clog2(N_REQ_MAX);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_s;

endpackage

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter: combinational one-hot grant.
// Ports: clk, rst_n, req[N] in; gnt[N], gnt_id, gnt_valid out.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    logic [IW-1:0] idx;

    // Search begins one past the last winner and wraps.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_q) + k) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    // Reset to N-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else if (gnt_valid) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/mo_mul_arb.sv
// Shares one mo_mul among N_REQ requesters with tagged returns.
// Ports: req_valid/ready/a/b per requester; mul_a/b, mul_result
// to the multiplier; rsp_valid/rsp_data back; busy.
module mo_mul_arb
    import ntt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_a,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_b,
    output logic [DATA_WIDTH-1:0]               mul_a,
    output logic [DATA_WIDTH-1:0]               mul_b,
    input  logic [DATA_WIDTH-1:0]               mul_result,
    output logic [N_REQ-1:0]                    rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic                                busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    // tag_q[k] is the op issued k+1 cycles ago; the last
    // stage lines up with mul_result.
    mul_tag_s       tag_q [MUL_LAT+1];
    logic [CW-1:0]  cnt_q [N_REQ];

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic             gnt_valid;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = tag_q[MUL_LAT].valid &&
                (tag_q[MUL_LAT].id == TAG_ID_W'(i));
        end
    end

    assign rsp_data = mul_result;

    // A returning result frees a slot in the same cycle,
    // so a full requester may be re-granted immediately.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = (cnt_q[i] < CW'(MAX_OUT)) | rsp_valid[i];
        end
    end

    assign arb_req   = req_valid & elig & {N_REQ{rst_n}};
    assign req_ready = gnt;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= MUL_LAT; k++) begin
            busy = busy | tag_q[k].valid;
        end
    end

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (gnt_valid) begin
                mul_a <= req_a[gnt_id];
                mul_b <= req_b[gnt_id];
            end
            tag_q[0] <= '{valid: gnt_valid,
                          id: TAG_ID_W'(gnt_id)};
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && !rsp_valid[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!gnt[i] && rsp_valid[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

endmodule
